// File: rtl/trigger_pkg.sv
// Shared constants for the Sdtrig trigger CSR file: addresses, trigger types, bit positions.
// TRIGGER_ICOUNT_EN selects whether icount (type 3) triggers are supported.
package trigger_pkg;

  localparam logic [11:0] CSR_TSELECT  = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1   = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2   = 12'h7A2;
  localparam logic [11:0] CSR_TDATA3   = 12'h7A3;
  localparam logic [11:0] CSR_TINFO    = 12'h7A4;
  localparam logic [11:0] CSR_TCONTROL = 12'h7A5;
  localparam logic [11:0] CSR_MCONTEXT = 12'h7A8;

  typedef enum logic [3:0] {
    TT_MCONTROL  = 4'd2,
    TT_ICOUNT    = 4'd3,
    TT_ITRIGGER  = 4'd4,
    TT_ETRIGGER  = 4'd5,
    TT_MCONTROL6 = 4'd6,
    TT_TMEXT     = 4'd7
  } trig_type_e;

  localparam int HIT_MCONTROL  = 20;
  localparam int HIT_MCONTROL6 = 22;
  localparam int HIT_ICOUNT    = 24;
  localparam int HIT_OTHER     = 26;

  localparam int TDATA1_DMODE = 27;
  localparam int ICOUNT_LSB   = 10;
  localparam int ICOUNT_MSB   = 23;
  localparam int ICOUNT_W     = ICOUNT_MSB - ICOUNT_LSB + 1;
  localparam int ICOUNT_M     = 9;

  localparam int TCONTROL_MTE  = 3;
  localparam int TCONTROL_MPTE = 7;

  localparam logic [31:0] TDATA1_RESET = 32'h2000_0000;

`ifdef TRIGGER_ICOUNT_EN
  localparam logic [31:0] TINFO_VALUE      = 32'h0000_00FC;
  localparam bit          ICOUNT_SUPPORTED = 1'b1;
`else
  localparam logic [31:0] TINFO_VALUE      = 32'h0000_00F4;
  localparam bit          ICOUNT_SUPPORTED = 1'b0;
`endif

  // Type 0 (no trigger) is a legal value to park a trigger in.
  function automatic logic type_supported(input logic [3:0] t);
    case (t)
      4'd0, TT_MCONTROL, TT_ITRIGGER, TT_ETRIGGER, TT_MCONTROL6, TT_TMEXT: return 1'b1;
      TT_ICOUNT: return ICOUNT_SUPPORTED;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] hit_mask(input logic [3:0] t);
    case (t)
      TT_MCONTROL:                      return 32'h1 << HIT_MCONTROL;
      TT_MCONTROL6:                     return 32'h1 << HIT_MCONTROL6;
      TT_ICOUNT:                        return 32'h1 << HIT_ICOUNT;
      TT_ITRIGGER, TT_ETRIGGER, TT_TMEXT: return 32'h1 << HIT_OTHER;
      default:                          return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/trigger_icount_ctr.sv
// Next-value logic for the count field of one icount trigger.
// The tdata1 register itself lives in trigger_csr_file; this block decides what its count field becomes.
module trigger_icount_ctr
  import trigger_pkg::*;
(
  input  logic [3:0]          trig_type,
  input  logic                m_en,
  input  logic                count_en,
  input  logic                hold,
  input  logic                load,
  input  logic [ICOUNT_W-1:0] load_value,
  input  logic [ICOUNT_W-1:0] count,
  output logic [ICOUNT_W-1:0] next_count
);

  // A CSR load beats everything; a hit-bit set in the same cycle holds the count.
  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_value;
    end else if (!hold && (trig_type == TT_ICOUNT) && m_en && count_en && (count != '0)) begin
      next_count = count - ICOUNT_W'(1);
    end
  end

endmodule

// File: rtl/trigger_csr_file.sv
// Sdtrig CSR state and sequential trigger state (hit bits, icount, tcontrol MTE/MPTE).
// Build option: TRIGGER_ICOUNT_EN adds icount (type 3) trigger support.
module trigger_csr_file
  import trigger_pkg::*;
#(
  parameter int NUM_TRIGGERS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             csr_addr,
  input  logic                    csr_we,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  output logic                    csr_hit,
  input  logic                    debug_mode,
  input  logic                    trap_taken,
  input  logic                    mret,
  input  logic                    instruction_retired,
  input  logic [NUM_TRIGGERS-1:0] trig_hit,
  output logic [1:0]              tselect,
  output logic [31:0]             tdata1 [NUM_TRIGGERS],
  output logic [31:0]             tdata2 [NUM_TRIGGERS],
  output logic [31:0]             tdata3 [NUM_TRIGGERS],
  output logic [31:0]             tcontrol,
  output logic [31:0]             mcontext,
  output logic [31:0]             icount_counter [NUM_TRIGGERS]
);

  logic                    mte;
  logic                    mpte;
  logic                    sel_locked;
  logic [31:0]             tdata1_legal;
  logic [31:0]             tdata1_next [NUM_TRIGGERS];
  logic [NUM_TRIGGERS-1:0] wr_tdata1;
  logic [NUM_TRIGGERS-1:0] wr_tdata2;
  logic [NUM_TRIGGERS-1:0] wr_tdata3;
  logic                    wr_tselect;
  logic                    wr_tcontrol;
  logic                    wr_mcontext;

  always_comb begin
    tcontrol                = '0;
    tcontrol[TCONTROL_MTE]  = mte;
    tcontrol[TCONTROL_MPTE] = mpte;
  end

  // A trigger owned by Debug Mode cannot be touched from M-mode.
  assign sel_locked  = tdata1[tselect][TDATA1_DMODE] && !debug_mode;
  assign wr_tselect  = csr_we && (csr_addr == CSR_TSELECT);
  assign wr_tcontrol = csr_we && (csr_addr == CSR_TCONTROL);
  assign wr_mcontext = csr_we && (csr_addr == CSR_MCONTEXT);

  always_comb begin
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      wr_tdata1[i] = csr_we && (csr_addr == CSR_TDATA1) && (tselect == 2'(i)) && !sel_locked;
      wr_tdata2[i] = csr_we && (csr_addr == CSR_TDATA2) && (tselect == 2'(i)) && !sel_locked;
      wr_tdata3[i] = csr_we && (csr_addr == CSR_TDATA3) && (tselect == 2'(i)) && !sel_locked;
    end
  end

  always_comb begin
    tdata1_legal = csr_wdata;
    if (!debug_mode) begin
      tdata1_legal[TDATA1_DMODE] = 1'b0;
    end
    if (!type_supported(tdata1_legal[31:28])) begin
      tdata1_legal = '0;
    end
  end

`ifdef TRIGGER_ICOUNT_EN
  logic [ICOUNT_W-1:0] icount_next [NUM_TRIGGERS];
  logic                count_en;

  assign count_en = instruction_retired && mte && !debug_mode;

  for (genvar g = 0; g < NUM_TRIGGERS; g++) begin : g_icount
    trigger_icount_ctr u_ctr (
      .trig_type  (tdata1[g][31:28]),
      .m_en       (tdata1[g][ICOUNT_M]),
      .count_en   (count_en),
      .hold       (trig_hit[g]),
      .load       (wr_tdata1[g]),
      .load_value (tdata1_legal[ICOUNT_MSB:ICOUNT_LSB]),
      .count      (tdata1[g][ICOUNT_MSB:ICOUNT_LSB]),
      .next_count (icount_next[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      icount_counter[i] = (tdata1[i][31:28] == TT_ICOUNT) ?
                          32'(tdata1[i][ICOUNT_MSB:ICOUNT_LSB]) : '0;
    end
  end
`else
  logic unused_retired;
  assign unused_retired = instruction_retired;

  always_comb begin
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      icount_counter[i] = '0;
    end
  end
`endif

  // Write beats hit-bit set, which beats the icount decrement.
  always_comb begin
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      tdata1_next[i] = tdata1[i];
`ifdef TRIGGER_ICOUNT_EN
      tdata1_next[i][ICOUNT_MSB:ICOUNT_LSB] = icount_next[i];
`endif
      if (wr_tdata1[i]) begin
        tdata1_next[i] = tdata1_legal;
      end else if (trig_hit[i]) begin
        tdata1_next[i] = tdata1_next[i] | hit_mask(tdata1[i][31:28]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tselect  <= '0;
      mte      <= 1'b0;
      mpte     <= 1'b0;
      mcontext <= '0;
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        tdata1[i] <= TDATA1_RESET;
        tdata2[i] <= '0;
        tdata3[i] <= '0;
      end
    end else begin
      if (wr_tselect && (csr_wdata < 32'(NUM_TRIGGERS))) begin
        tselect <= csr_wdata[1:0];
      end
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        tdata1[i] <= tdata1_next[i];
        if (wr_tdata2[i]) tdata2[i] <= csr_wdata;
        if (wr_tdata3[i]) tdata3[i] <= csr_wdata;
      end
      // A trap blocks a simultaneous MRET even when Debug Mode suppresses the save.
      if (wr_tcontrol) begin
        mte  <= csr_wdata[TCONTROL_MTE];
        mpte <= csr_wdata[TCONTROL_MPTE];
      end else if (trap_taken) begin
        if (!debug_mode) begin
          mpte <= mte;
          mte  <= 1'b0;
        end
      end else if (mret) begin
        mte <= mpte;
      end
      if (wr_mcontext) begin
        mcontext <= csr_wdata;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_addr)
      CSR_TSELECT:  csr_rdata = {30'b0, tselect};
      CSR_TDATA1:   csr_rdata = tdata1[tselect];
      CSR_TDATA2:   csr_rdata = tdata2[tselect];
      CSR_TDATA3:   csr_rdata = tdata3[tselect];
      CSR_TINFO:    csr_rdata = TINFO_VALUE;
      CSR_TCONTROL: csr_rdata = tcontrol;
      CSR_MCONTEXT: csr_rdata = mcontext;
      default:      csr_hit   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trigger_csr_file.sv
// Directed, table-driven bench for trigger_csr_file with hand-computed expectations.
// Expected tinfo and icount behaviour follow whether TRIGGER_ICOUNT_EN is defined.
module tb_trigger_csr_file;

  localparam int NT = 4;

`ifdef TRIGGER_ICOUNT_EN
  localparam logic [31:0] TINFO_EXP = 32'h0000_00FC;
`else
  localparam logic [31:0] TINFO_EXP = 32'h0000_00F4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   csr_addr;
  logic          csr_we;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic          debug_mode;
  logic          trap_taken;
  logic          mret;
  logic          instruction_retired;
  logic [NT-1:0] trig_hit;
  logic [1:0]    tselect;
  logic [31:0]   tdata1 [NT];
  logic [31:0]   tdata2 [NT];
  logic [31:0]   tdata3 [NT];
  logic [31:0]   tcontrol;
  logic [31:0]   mcontext;
  logic [31:0]   icount_counter [NT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [11:0]   addr;
    logic [31:0]   wdata;
    logic          dbg;
    logic          trap;
    logic          ret_mret;
    logic          retire;
    logic [NT-1:0] hit;
    logic [11:0]   chk_addr;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs[$];

  trigger_csr_file #(.NUM_TRIGGERS(NT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .csr_addr            (csr_addr),
    .csr_we              (csr_we),
    .csr_wdata           (csr_wdata),
    .csr_rdata           (csr_rdata),
    .csr_hit             (csr_hit),
    .debug_mode          (debug_mode),
    .trap_taken          (trap_taken),
    .mret                (mret),
    .instruction_retired (instruction_retired),
    .trig_hit            (trig_hit),
    .tselect             (tselect),
    .tdata1              (tdata1),
    .tdata2              (tdata2),
    .tdata3              (tdata3),
    .tcontrol            (tcontrol),
    .mcontext            (mcontext),
    .icount_counter      (icount_counter)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic dbg, input logic trap, input logic ret_mret,
                               input logic retire, input logic [NT-1:0] hit,
                               input logic [11:0] chk_addr, input logic [31:0] exp);
    vec_t v;
    v.we = we;  v.addr = addr;  v.wdata = wdata;  v.dbg = dbg;  v.trap = trap;
    v.ret_mret = ret_mret;  v.retire = retire;  v.hit = hit;
    v.chk_addr = chk_addr;  v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of inputs, clear the strobes after the edge and point the read port at chk_addr.
  task automatic apply_stimulus(input vec_t v);
    csr_we              = v.we;
    csr_addr            = v.addr;
    csr_wdata           = v.wdata;
    debug_mode          = v.dbg;
    trap_taken          = v.trap;
    mret                = v.ret_mret;
    instruction_retired = v.retire;
    trig_hit            = v.hit;
    @(posedge clk);
    #1;
    csr_we              = 1'b0;
    trap_taken          = 1'b0;
    mret                = 1'b0;
    instruction_retired = 1'b0;
    trig_hit            = '0;
    csr_addr            = v.chk_addr;
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check_output(name, csr_rdata, exp);
  endtask

  initial begin
    rst = 1'b1;  csr_addr = '0;  csr_we = 1'b0;  csr_wdata = '0;  debug_mode = 1'b0;
    trap_taken = 1'b0;  mret = 1'b0;  instruction_retired = 1'b0;  trig_hit = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    read_check("reset_tdata1", 12'h7A1, 32'h2000_0000);
    read_check("reset_tcontrol", 12'h7A5, 32'h0);
    read_check("reset_tinfo", 12'h7A4, TINFO_EXP);
    read_check("reset_tselect", 12'h7A0, 32'h0);
    check_output("reset_tdata1_3", tdata1[3], 32'h2000_0000);
    check_output("reset_icount_0", icount_counter[0], 32'h0);

    //           we    addr     wdata         dbg   trap  mret  ret   hit      chk      exp
    vecs.push_back(mkv(1, 12'h7A0, 32'd5,         0, 0, 0, 0, 4'b0000, 12'h7A0, 32'h0));
    vecs.push_back(mkv(1, 12'h7A0, 32'd2,         0, 0, 0, 0, 4'b0000, 12'h7A0, 32'h2));
    vecs.push_back(mkv(1, 12'h7A2, 32'h8000_0010, 0, 0, 0, 0, 4'b0000, 12'h7A2, 32'h8000_0010));
    vecs.push_back(mkv(1, 12'h7A1, 32'h6800_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h6000_0000));
    vecs.push_back(mkv(1, 12'h7A1, 32'h9000_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    vecs.push_back(mkv(1, 12'h7A1, 32'h1000_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    vecs.push_back(mkv(1, 12'h7A1, 32'h2800_0040, 1, 0, 0, 0, 4'b0000, 12'h7A1, 32'h2800_0040));
    vecs.push_back(mkv(1, 12'h7A2, 32'h0000_1234, 0, 0, 0, 0, 4'b0000, 12'h7A2, 32'h8000_0010));
    vecs.push_back(mkv(1, 12'h7A1, 32'h2000_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h2800_0040));
    vecs.push_back(mkv(1, 12'h7A1, 32'h2000_0000, 1, 0, 0, 0, 4'b0000, 12'h7A1, 32'h2000_0000));
    vecs.push_back(mkv(1, 12'h7A8, 32'hDEAD_BEEF, 0, 0, 0, 0, 4'b0000, 12'h7A8, 32'hDEAD_BEEF));
    vecs.push_back(mkv(1, 12'h7A5, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'b0000, 12'h7A5, 32'h88));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         0, 1, 0, 0, 4'b0000, 12'h7A5, 32'h80));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         0, 0, 1, 0, 4'b0000, 12'h7A5, 32'h88));
    vecs.push_back(mkv(1, 12'h7A5, 32'h08,        0, 0, 0, 0, 4'b0000, 12'h7A5, 32'h08));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         0, 1, 0, 0, 4'b0000, 12'h7A5, 32'h80));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         0, 0, 1, 0, 4'b0000, 12'h7A5, 32'h88));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         0, 1, 1, 0, 4'b0000, 12'h7A5, 32'h80));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         1, 1, 0, 0, 4'b0000, 12'h7A5, 32'h80));
    vecs.push_back(mkv(1, 12'h7A5, 32'h08,        0, 0, 0, 0, 4'b0000, 12'h7A5, 32'h08));
    vecs.push_back(mkv(0, 12'h7A5, 32'h0,         0, 0, 1, 0, 4'b0000, 12'h7A5, 32'h00));
    vecs.push_back(mkv(0, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0100, 12'h7A1, 32'h2010_0000));
    vecs.push_back(mkv(0, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h2010_0000));
    vecs.push_back(mkv(1, 12'h7A1, 32'h6000_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h6000_0000));
    vecs.push_back(mkv(0, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0100, 12'h7A1, 32'h6040_0000));
    vecs.push_back(mkv(1, 12'h7A1, 32'h5000_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h5000_0000));
    vecs.push_back(mkv(0, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0100, 12'h7A1, 32'h5400_0000));
    vecs.push_back(mkv(1, 12'h7A1, 32'h4000_0000, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h4000_0000));
    vecs.push_back(mkv(0, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0100, 12'h7A1, 32'h4400_0000));
    vecs.push_back(mkv(1, 12'h7A0, 32'h0,         0, 0, 0, 0, 4'b0001, 12'h7A1, 32'h2010_0000));
    vecs.push_back(mkv(1, 12'h7A1, 32'h2000_0004, 0, 0, 0, 0, 4'b0001, 12'h7A1, 32'h2000_0004));
    vecs.push_back(mkv(1, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    vecs.push_back(mkv(0, 12'h7A1, 32'h0,         0, 0, 0, 0, 4'b0001, 12'h7A1, 32'h0));
    vecs.push_back(mkv(1, 12'h7A4, 32'h0,         0, 0, 0, 0, 4'b0000, 12'h7A4, TINFO_EXP));
    vecs.push_back(mkv(1, 12'h7A6, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'b0000, 12'h7A6, 32'h0));
    vecs.push_back(mkv(1, 12'h7A3, 32'hCAFE_0003, 0, 0, 0, 0, 4'b0000, 12'h7A3, 32'hCAFE_0003));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), csr_rdata, vecs[i].exp);
    end

    check_output("tdata1_2_final", tdata1[2], 32'h4400_0000);
    check_output("tdata2_2_final", tdata2[2], 32'h8000_0010);
    check_output("tdata2_0_final", tdata2[0], 32'h0);
    check_output("tdata3_0_final", tdata3[0], 32'hCAFE_0003);
    check_output("mcontext_port", mcontext, 32'hDEAD_BEEF);
    check_output("tselect_port", 32'(tselect), 32'h0);
    csr_addr = 12'h7A6;
    #1;
    check_output("csr_hit_unmapped", 32'(csr_hit), 32'h0);
    csr_addr = 12'h7A8;
    #1;
    check_output("csr_hit_mcontext", 32'(csr_hit), 32'h1);

`ifdef TRIGGER_ICOUNT_EN
    apply_stimulus(mkv(1, 12'h7A0, 32'd1, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_trig1_reset", csr_rdata, 32'h2000_0000);
    apply_stimulus(mkv(1, 12'h7A1, 32'h3000_0E00, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_load", csr_rdata, 32'h3000_0E00);
    check_output("icnt_cnt3", icount_counter[1], 32'd3);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_mte0_hold", icount_counter[1], 32'd3);
    apply_stimulus(mkv(1, 12'h7A5, 32'h08, 0, 0, 0, 0, 4'b0000, 12'h7A5, 32'h0));
    check_output("icnt_mte_set", csr_rdata, 32'h08);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_cnt2", icount_counter[1], 32'd2);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 1, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_debug_hold", icount_counter[1], 32'd2);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_cnt1", icount_counter[1], 32'd1);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_cnt0", icount_counter[1], 32'd0);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_saturate", icount_counter[1], 32'd0);
    check_output("icnt_tdata1_zero", csr_rdata, 32'h3000_0200);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 0, 4'b0010, 12'h7A1, 32'h0));
    check_output("icnt_hit24", csr_rdata, 32'h3100_0200);
`else
    apply_stimulus(mkv(1, 12'h7A0, 32'd1, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_trig1_reset", csr_rdata, 32'h2000_0000);
    apply_stimulus(mkv(1, 12'h7A1, 32'h3000_0E00, 0, 0, 0, 0, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_type3_illegal", csr_rdata, 32'h0);
    apply_stimulus(mkv(0, 12'h7A1, 32'h0, 0, 0, 0, 1, 4'b0000, 12'h7A1, 32'h0));
    check_output("icnt_tied_zero", icount_counter[1], 32'h0);
`endif

    // Reset asserted alongside a write: the write must be lost.
    rst       = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = 12'h7A8;
    csr_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    csr_we = 1'b0;
    #1;
    check_output("rst_wr_mcontext", mcontext, 32'h0);
    check_output("rst_wr_tselect", 32'(tselect), 32'h0);
    check_output("rst_wr_tdata1_2", tdata1[2], 32'h2000_0000);
    check_output("rst_wr_tcontrol", tcontrol, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_csr_file.md
# trigger_csr_file

Register-side counterpart of the trigger matching logic. It holds the Sdtrig CSR state (`tselect`, `tdata1/2/3` per trigger, `tcontrol`, `mcontext`, `tinfo`) and serves the core's CSR read/write port, legalising each write. It keeps the sequential trigger state: the icount down-counters, the per-trigger hit bits and the `tcontrol` MTE/MPTE save and restore. Its register outputs feed the combinational matcher, and the matcher's per-trigger hit vector comes back in.

## Interface
Parameters:
- `NUM_TRIGGERS`, 4: number of triggers; `tselect` is 2 bits wide, so the maximum is 4.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `csr_addr` in 12: CSR address.
- `csr_we` in 1: write strobe.
- `csr_wdata` in 32: write data, already resolved for set/clear.
- `csr_rdata` out 32: read data, combinational.
- `csr_hit` out 1: `csr_addr` is one of this block's CSRs.
- `debug_mode` in 1: core is in Debug Mode.
- `trap_taken` in 1: a trap into M-mode is taken this cycle.
- `mret` in 1: MRET retires this cycle.
- `instruction_retired` in 1: an instruction retires this cycle.
- `trig_hit` in NUM_TRIGGERS: per-trigger match pulse from the matcher.
- `tselect` out 2: current tselect.
- `tdata1`, `tdata2`, `tdata3` out [NUM_TRIGGERS][32]: trigger registers.
- `tcontrol` out 32: tcontrol; MTE is bit 3, MPTE is bit 7.
- `mcontext` out 32: mcontext.
- `icount_counter` out [NUM_TRIGGERS][32]: per-trigger icount value, zero-extended.

## Operation
- **Address map.** 0x7A0 tselect, 0x7A1–0x7A3 tdata1–3 of the selected trigger, 0x7A4 tinfo (read-only), 0x7A5 tcontrol, 0x7A8 mcontext. For any other address, `csr_hit`=0 and `csr_rdata`=0.
- **tselect (WARL).** A write with value < NUM_TRIGGERS takes effect; any other value is ignored.
- **tdata1 write legalisation.**
  - If the stored dmode bit (27) is 1 and `debug_mode`=0: writes to tdata1, tdata2 and tdata3 of that trigger are ignored.
  - If `debug_mode`=0: a written dmode bit is forced to 0.
  - Type field [31:28] not in {0,2,3,4,5,6,7}: the whole tdata1 is stored as 0.
- **Hit bits**, set on a `trig_hit[i]` pulse:
  - type 2: bit 20
  - type 6: bit 22
  - type 3: bit 24
  - types 4, 5, 7: bit 26
  - Hit bits are sticky until software clears them.
- **icount.**
  - The count field is tdata1[23:10] and is mirrored on `icount_counter[i][13:0]`.
  - It decrements by 1 when all of the following hold: type is 3, `instruction_retired`, MTE=1, `debug_mode`=0, m bit (9)=1, count != 0.
  - At 0 it saturates; it does not wrap.
- **tcontrol.**
  - On `trap_taken` with `debug_mode`=0: MPTE<=MTE, MTE<=0.
  - On `mret`: MTE<=MPTE, MPTE unchanged.
  - All other bits read as 0 and are not writable.
- **tinfo** reads 0x0000_00FC, or 0x0000_00F4 when icount is not compiled in.
- **Priority** for the same register in the same cycle: CSR write > hit-bit set > icount decrement. If `trap_taken` and `mret` occur together, `trap_taken` wins.

## Timing
- **Reset values:**
  - tselect=0
  - all tdata1=0x2000_0000 (type 2, all enables 0)
  - tdata2=0, tdata3=0
  - tcontrol=0, mcontext=0
  - hence `icount_counter`=0
- CSR writes are visible on outputs and reads the cycle after `csr_we`; reads are same-cycle combinational.
- Hit-bit set, icount decrement and MTE/MPTE updates are single-cycle: they appear on outputs at the next edge.
- Reset during a CSR write: reset wins and the write is lost.
- No handshake; every write completes in one cycle.

## Configuration
- `TRIGGER_ICOUNT_EN` defined: type 3 is supported as described.
- `TRIGGER_ICOUNT_EN` undefined:
  - a type-3 write legalises tdata1 to 0
  - no decrement logic is present
  - `icount_counter` is tied to 0
  - tinfo bit 3 is 0

## Structure
- Package `trigger_pkg` holds:
  - CSR address localparams
  - trigger type enum (2..7)
  - hit-bit positions
  - tcontrol bit positions
  - tinfo constants
- Sub-module `trigger_icount_ctr`: one instance per trigger, generated under `TRIGGER_ICOUNT_EN`. It handles decrement/saturate and the CSR-load override.

## Test plan
- Reset, then read 0x7A1 -> 0x2000_0000; read 0x7A5 -> 0; read 0x7A4 -> 0xFC.
- Write tselect=5 with NUM_TRIGGERS=4 -> tselect stays at its prior value. Write tselect=2, then tdata2=0x8000_0010 -> `tdata2[2]`=0x8000_0010; other triggers unchanged.
- With `debug_mode`=0, write tdata1=0x6800_0000 -> stored 0x6000_0000. Write type 9 -> stored 0.
- Load icount type 3, count=3, m=1, MTE=1; retire 3 instructions -> counter 2,1,0 on consecutive cycles, then holds at 0. Drive `trig_hit` -> bit 24 set.
- MTE=1; pulse `trap_taken` -> MTE=0, MPTE=1; pulse `mret` -> MTE=1.
- Same cycle: CSR write tdata1=0x2000_0004 and `trig_hit` on that trigger -> stored 0x2000_0004, with hit bit 20 clear.
